// File: rtl/alu_core_pkg.sv
// Shared opcode and state encodings plus default datapath widths for the ALU core.
package alu_core_pkg;

    localparam int ALU_IN_OP_WIDTH_DEF      = 8;
    localparam int ALU_OUT_RESULT_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        NO_OP  = 3'b000,
        ADD_OP = 3'b001,
        AND_OP = 3'b010,
        XOR_OP = 3'b011,
        MUL_OP = 3'b100
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        MUL  = 2'd2
    } alu_core_state_t;

endpackage

// File: rtl/alu_core_if.sv
// Request/response bundle between the alu_in agent, the ALU core and the alu_out stage.
interface alu_core_if
    import alu_core_pkg::*;
#(
    parameter int OP_W  = ALU_IN_OP_WIDTH_DEF,
    parameter int RES_W = ALU_OUT_RESULT_WIDTH_DEF
) ();
    logic [2:0]       alu_op;
    logic [OP_W-1:0]  a;
    logic [OP_W-1:0]  b;
    logic             valid;
    logic             ready;
    logic             done;
    logic [RES_W-1:0] result;

    modport master (output alu_op, a, b, valid, input ready, done, result);
    modport slave  (input alu_op, a, b, valid, output ready, done, result);
endinterface

// File: rtl/alu_core_mult.sv
// Iterative shift-add multiplier: one multiplier bit per edge, OP_W edges per product
// (fewer with ALU_CORE_MUL_EARLY_EXIT_EN); start is only honoured by the caller when idle.
module alu_core_mult
    import alu_core_pkg::*;
#(
    parameter int OP_W  = ALU_IN_OP_WIDTH_DEF,
    parameter int RES_W = ALU_OUT_RESULT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    output logic             busy,
    output logic [RES_W-1:0] product,
    output logic             product_valid
);
    localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [RES_W-1:0] acc_q, acc_d;
    logic [OP_W-1:0]  a_q, a_d;
    logic [OP_W-1:0]  b_q, b_d;

    logic [RES_W-1:0] a_ext;
    logic [RES_W-1:0] acc_nxt;
    logic             last;

    assign a_ext   = {{(RES_W-OP_W){1'b0}}, a_q};
    assign acc_nxt = b_q[count_q] ? (acc_q + (a_ext << count_q)) : acc_q;

`ifdef ALU_CORE_MUL_EARLY_EXIT_EN
    logic [CNT_W:0] cnt_nxt;
    assign cnt_nxt = {1'b0, count_q} + (CNT_W+1)'(1);
    // Stop as soon as no multiplier bits remain above the one consumed this edge.
    assign last    = ((b_q >> cnt_nxt) == '0);
`else
    assign last    = (count_q == CNT_W'(OP_W-1));
`endif

    assign busy          = busy_q;
    assign product       = acc_nxt;
    assign product_valid = busy_q && last;

    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        if (start) begin
            busy_d  = 1'b1;
            count_d = '0;
            acc_d   = '0;
            a_d     = a;
            b_d     = b;
        end else if (busy_q) begin
            acc_d   = acc_nxt;
            count_d = count_q + CNT_W'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: rtl/alu_core.sv
// Sequential ALU: ADD/AND/XOR done one cycle after acceptance, MUL via alu_core_mult.
// Single outstanding request (ready only in IDLE); ALU_CORE_MUL_EARLY_EXIT_EN shortens MUL.
module alu_core
    import alu_core_pkg::*;
#(
    parameter int ALU_IN_OP_WIDTH      = ALU_IN_OP_WIDTH_DEF,
    parameter int ALU_OUT_RESULT_WIDTH = ALU_OUT_RESULT_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst,
    alu_core_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_MUL  = MUL;

    if (ALU_OUT_RESULT_WIDTH < 2*ALU_IN_OP_WIDTH) begin : g_width_err
        $error("alu_core: ALU_OUT_RESULT_WIDTH must be >= 2*ALU_IN_OP_WIDTH");
    end

    logic [1:0]                      state_q, state_d;
    logic                            done_q, done_d;
    logic [ALU_OUT_RESULT_WIDTH-1:0] result_q, result_d;
    logic [2:0]                      op_q, op_d;
    logic [ALU_IN_OP_WIDTH-1:0]      a_q, a_d;
    logic [ALU_IN_OP_WIDTH-1:0]      b_q, b_d;

    logic                            accept;
    logic                            mul_start;
    logic                            mul_busy;
    logic                            mul_vld;
    logic [ALU_OUT_RESULT_WIDTH-1:0] mul_product;
    logic [ALU_OUT_RESULT_WIDTH-1:0] calc_res;

    assign bus.ready  = (state_q == ST_IDLE) && !rst;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign accept     = bus.valid && bus.ready;

    always_comb begin
        case (op_q)
            ADD_OP:  calc_res = ALU_OUT_RESULT_WIDTH'(a_q) + ALU_OUT_RESULT_WIDTH'(b_q);
            AND_OP:  calc_res = ALU_OUT_RESULT_WIDTH'(a_q & b_q);
            default: calc_res = ALU_OUT_RESULT_WIDTH'(a_q ^ b_q);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        result_d  = result_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.alu_op)
                        ADD_OP, AND_OP, XOR_OP: begin
                            op_d    = bus.alu_op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            state_d = ST_CALC;
                        end
                        MUL_OP: begin
                            op_d      = bus.alu_op;
                            a_d       = bus.a;
                            b_d       = bus.b;
                            mul_start = 1'b1;
                            state_d   = ST_MUL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                result_d = calc_res;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            ST_MUL: begin
                if (mul_vld) begin
                    result_d = mul_product;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else if (!mul_busy) begin
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            op_q     <= NO_OP;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    alu_core_mult #(
        .OP_W  (ALU_IN_OP_WIDTH),
        .RES_W (ALU_OUT_RESULT_WIDTH)
    ) u_mult (
        .clk           (clk),
        .rst           (rst),
        .start         (mul_start),
        .a             (bus.a),
        .b             (bus.b),
        .busy          (mul_busy),
        .product       (mul_product),
        .product_valid (mul_vld)
    );

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core; MUL latency expectations follow ALU_CORE_MUL_EARLY_EXIT_EN.
module tb_alu_core;
    import alu_core_pkg::*;

`ifdef ALU_CORE_MUL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_core_if #(.OP_W(8), .RES_W(16)) bus ();

    alu_core #(
        .ALU_IN_OP_WIDTH      (8),
        .ALU_OUT_RESULT_WIDTH (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one request for a single edge; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        bus.alu_op = op;
        bus.a      = x;
        bus.b      = y;
        bus.valid  = 1'b1;
        @(negedge clk);
        bus.valid  = 1'b0;
    endtask

    // Counts edges after acceptance until done, then checks latency and result.
    task automatic wait_done(input string tag, input int exp_lat, input logic [15:0] exp_res);
        int lat;
        lat = 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, bus.result, exp_res);
    endtask

    initial begin
        int seen;
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        bus.alu_op = NO_OP;
        bus.a     = '0;
        bus.b     = '0;
        bus.valid = 1'b0;

        @(negedge clk);
        check("rst_ready", bus.ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_result", bus.result, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", bus.ready, 1);

        // ADD with carry out of the operand width
        issue(ADD_OP, 8'hFF, 8'h01);
        check("add_busy_ready", bus.ready, 0);
        check("add_busy_done", bus.done, 0);
        wait_done("add", 1, 16'h0100);
        check("add_done_ready", bus.ready, 1);
        @(negedge clk);
        check("add_pulse", bus.done, 0);
        check("add_hold", bus.result, 16'h0100);

        // AND, then XOR accepted in the done cycle
        @(negedge clk);
        bus.alu_op = AND_OP; bus.a = 8'hF0; bus.b = 8'h3C; bus.valid = 1'b1;
        @(negedge clk);
        bus.alu_op = XOR_OP; bus.a = 8'hAA; bus.b = 8'h0F;
        @(negedge clk);
        check("and_done", bus.done, 1);
        check("and_res", bus.result, 16'h0030);
        check("and_ready", bus.ready, 1);
        @(negedge clk);
        bus.valid = 1'b0;
        check("b2b_gap", bus.done, 0);
        @(negedge clk);
        check("xor_done", bus.done, 1);
        check("xor_res", bus.result, 16'h00A5);

        // MUL with a stray request held during the multiply
        @(negedge clk);
        bus.alu_op = MUL_OP; bus.a = 8'hFF; bus.b = 8'hFF; bus.valid = 1'b1;
        @(negedge clk);
        bus.alu_op = ADD_OP; bus.a = 8'h01; bus.b = 8'h01;
        check("mul_ready", bus.ready, 0);
        wait_done("mul_ff", 8, 16'hFE01);
        bus.valid = 1'b0;
        @(negedge clk);
        check("mul_pulse", bus.done, 0);
        check("mul_hold", bus.result, 16'hFE01);

        // Illegal and no-op requests are dropped
        @(negedge clk);
        bus.alu_op = 3'b111; bus.a = 8'h11; bus.b = 8'h22; bus.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ill_ready", bus.ready, 1);
            check("ill_done", bus.done, 0);
        end
        bus.alu_op = NO_OP;
        @(negedge clk);
        check("nop_done", bus.done, 0);
        bus.valid = 1'b0;
        check("ill_result", bus.result, 16'hFE01);

        // Reset in the middle of a multiply
        issue(MUL_OP, 8'h12, 8'h34);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_ready", bus.ready, 0);
        check("abort_done", bus.done, 0);
        check("abort_result", bus.result, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        @(negedge clk);
        check("abort_idle", bus.ready, 1);
        for (int i = 0; i < 10; i++) begin
            if (bus.done) seen++;
            @(negedge clk);
        end
        check("abort_no_done", seen, 0);

        issue(MUL_OP, 8'h12, 8'h34);
        wait_done("mul_1234", EARLY ? 6 : 8, 16'h03A8);
        issue(MUL_OP, 8'h55, 8'h01);
        wait_done("mul_b1", EARLY ? 1 : 8, 16'h0055);
        issue(MUL_OP, 8'hAB, 8'h00);
        wait_done("mul_b0", EARLY ? 1 : 8, 16'h0000);
        issue(MUL_OP, 8'h03, 8'h80);
        wait_done("mul_b80", 8, 16'h0180);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
